// File: rtl/yuv_pkg.sv
// rtl/yuv_pkg.sv - BT.601 full-range coefficients and shared types for the RGB/YUV converters
package yuv_pkg;

    localparam int COORD_W = 10;
    localparam int PIX_W   = 8;
    localparam int PROD_W  = 16;
    localparam int SUM_W   = 18;

    // Luma weights (x256)
    localparam logic [PIX_W-1:0] KY_R = 8'd77;
    localparam logic [PIX_W-1:0] KY_G = 8'd150;
    localparam logic [PIX_W-1:0] KY_B = 8'd29;
    // Cb weights (x256); R and G terms are subtracted
    localparam logic [PIX_W-1:0] KU_R = 8'd43;
    localparam logic [PIX_W-1:0] KU_G = 8'd85;
    localparam logic [PIX_W-1:0] KU_B = 8'd128;
    // Cr weights (x256); G and B terms are subtracted
    localparam logic [PIX_W-1:0] KV_R = 8'd128;
    localparam logic [PIX_W-1:0] KV_G = 8'd107;
    localparam logic [PIX_W-1:0] KV_B = 8'd21;

    localparam int ROUND      = 128;
    localparam int CHROMA_OFS = 128;

    typedef struct packed {
        logic [PIX_W-1:0] y;
        logic [PIX_W-1:0] u;
        logic [PIX_W-1:0] v;
    } yuv_t;

    // Side-band information that travels down the pipeline with each pixel
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               last_col;
        logic               frame_last;
    } pix_tag_t;

    // Zero-extend an unsigned product into the signed accumulator width
    function automatic logic signed [SUM_W-1:0] widen(input logic [PROD_W-1:0] p);
        return $signed({2'b00, p});
    endfunction

    // Saturate a signed intermediate to an 8-bit unsigned sample
    function automatic logic [PIX_W-1:0] clamp_u8(input logic signed [SUM_W-1:0] val);
        if (val < 18'sd0) begin
            return 8'd0;
        end else if (val > 18'sd255) begin
            return 8'd255;
        end else begin
            return val[PIX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/rgb2yuv_core.sv
// rtl/rgb2yuv_core.sv - three-stage RGB to per-pixel YUV datapath (products, sums, round/clamp)
module rgb2yuv_core
    import yuv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [PIX_W-1:0] i_r,
    input  logic [PIX_W-1:0] i_g,
    input  logic [PIX_W-1:0] i_b,
    output logic             o_valid,
    output yuv_t             o_yuv
);

    localparam logic signed [SUM_W-1:0] RND = SUM_W'(ROUND);
    localparam logic signed [SUM_W-1:0] OFS = SUM_W'(CHROMA_OFS);

    logic                    r_s1_valid;
    logic                    r_s2_valid;
    logic                    r_s3_valid;
    logic [PROD_W-1:0]       r_p_yr, r_p_yg, r_p_yb;
    logic [PROD_W-1:0]       r_p_ur, r_p_ug, r_p_ub;
    logic [PROD_W-1:0]       r_p_vr, r_p_vg, r_p_vb;
    logic signed [SUM_W-1:0] r_sum_y, r_sum_u, r_sum_v;
    yuv_t                    r_yuv;

    logic signed [SUM_W-1:0] w_y_sh, w_u_sh, w_v_sh;

    // Valid bits are the only reset state; data registers are qualified by them
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
        end else begin
            r_s1_valid <= i_valid;
            r_s2_valid <= r_s1_valid;
            r_s3_valid <= r_s2_valid;
        end
    end

    // S1: all nine unsigned 8x8 products
    always_ff @(posedge clk) begin
        r_p_yr <= PROD_W'(i_r) * PROD_W'(KY_R);
        r_p_yg <= PROD_W'(i_g) * PROD_W'(KY_G);
        r_p_yb <= PROD_W'(i_b) * PROD_W'(KY_B);
        r_p_ur <= PROD_W'(i_r) * PROD_W'(KU_R);
        r_p_ug <= PROD_W'(i_g) * PROD_W'(KU_G);
        r_p_ub <= PROD_W'(i_b) * PROD_W'(KU_B);
        r_p_vr <= PROD_W'(i_r) * PROD_W'(KV_R);
        r_p_vg <= PROD_W'(i_g) * PROD_W'(KV_G);
        r_p_vb <= PROD_W'(i_b) * PROD_W'(KV_B);
    end

    // S2: signed sums; chroma may go negative before the offset is applied
    always_ff @(posedge clk) begin
        r_sum_y <= widen(r_p_yr) + widen(r_p_yg) + widen(r_p_yb);
        r_sum_u <= widen(r_p_ub) - widen(r_p_ur) - widen(r_p_ug);
        r_sum_v <= widen(r_p_vr) - widen(r_p_vg) - widen(r_p_vb);
    end

    assign w_y_sh = (r_sum_y + RND) >>> 8;
    assign w_u_sh = ((r_sum_u + RND) >>> 8) + OFS;
    assign w_v_sh = ((r_sum_v + RND) >>> 8) + OFS;

    // S3: floor-shift and saturate each component to 0..255
    always_ff @(posedge clk) begin
        r_yuv.y <= clamp_u8(w_y_sh);
        r_yuv.u <= clamp_u8(w_u_sh);
        r_yuv.v <= clamp_u8(w_v_sh);
    end

    assign o_valid = r_s3_valid;
    assign o_yuv   = r_yuv;

endmodule

// File: rtl/rgb_to_yuv422p.sv
// rtl/rgb_to_yuv422p.sv - raster RGB888 to YUV 4:2:2 with coordinates and frame-end flag
module rgb_to_yuv422p
    import yuv_pkg::*;
#(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 466
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               data_valid,
    input  logic               sof,
    input  logic [PIX_W-1:0]   r_in,
    input  logic [PIX_W-1:0]   g_in,
    input  logic [PIX_W-1:0]   b_in,
    output logic               y_valid,
    output logic [PIX_W-1:0]   y_out,
    output logic               uv_valid,
    output logic [PIX_W-1:0]   u_out,
    output logic [PIX_W-1:0]   v_out,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               frame_end
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_HEIGHT - 1);

    logic [COORD_W-1:0] r_x_cnt;
    logic [COORD_W-1:0] r_y_cnt;
    pix_tag_t           r_tag [3];
    logic [PIX_W-1:0]   r_hold_u;
    logic [PIX_W-1:0]   r_hold_v;
    logic               r_hold_valid;

    logic [COORD_W-1:0] w_px_x;
    logic [COORD_W-1:0] w_px_y;
    pix_tag_t           w_tag_in;
    logic               w_s3_valid;
    yuv_t               w_s3_yuv;
    pix_tag_t           w_s3_tag;
    logic [PIX_W-1:0]   w_u_avg;
    logic [PIX_W-1:0]   w_v_avg;

    // sof overrides the running counters so a frame can restart at any point
    assign w_px_x = sof ? '0 : r_x_cnt;
    assign w_px_y = sof ? '0 : r_y_cnt;

    assign w_tag_in.x          = w_px_x;
    assign w_tag_in.y          = w_px_y;
    assign w_tag_in.last_col   = (w_px_x == X_LAST);
    assign w_tag_in.frame_last = (w_px_x == X_LAST) && (w_px_y == Y_LAST);

    // Raster position of the next accepted pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_cnt <= '0;
            r_y_cnt <= '0;
        end else if (data_valid) begin
            if (w_px_x == X_LAST) begin
                r_x_cnt <= '0;
                r_y_cnt <= (w_px_y == Y_LAST) ? '0 : w_px_y + 1'b1;
            end else begin
                r_x_cnt <= w_px_x + 1'b1;
                r_y_cnt <= w_px_y;
            end
        end
    end

    rgb2yuv_core u_core (
        .clk     (clk),
        .rst     (rst),
        .i_valid (data_valid),
        .i_r     (r_in),
        .i_g     (g_in),
        .i_b     (b_in),
        .o_valid (w_s3_valid),
        .o_yuv   (w_s3_yuv)
    );

    // Side-band delay line matching the three core stages; gated downstream by the core valid
    always_ff @(posedge clk) begin
        r_tag[0] <= w_tag_in;
        r_tag[1] <= r_tag[0];
        r_tag[2] <= r_tag[1];
    end

    assign w_s3_tag = r_tag[2];
    assign w_u_avg  = PIX_W'((9'(r_hold_u) + 9'(w_s3_yuv.u) + 9'd1) >> 1);
    assign w_v_avg  = PIX_W'((9'(r_hold_v) + 9'(w_s3_yuv.v) + 9'd1) >> 1);

    // S4: chroma pairing and output registers; data outputs hold while their valid is low
    always_ff @(posedge clk) begin
        if (rst) begin
            y_valid      <= 1'b0;
            y_out        <= '0;
            uv_valid     <= 1'b0;
            u_out        <= '0;
            v_out        <= '0;
            pixel_x      <= '0;
            pixel_y      <= '0;
            frame_end    <= 1'b0;
            r_hold_u     <= '0;
            r_hold_v     <= '0;
            r_hold_valid <= 1'b0;
        end else begin
            y_valid   <= w_s3_valid;
            frame_end <= w_s3_valid && w_s3_tag.frame_last;
            uv_valid  <= 1'b0;
            if (w_s3_valid) begin
                y_out   <= w_s3_yuv.y;
                pixel_x <= w_s3_tag.x;
                pixel_y <= w_s3_tag.y;
                if (!w_s3_tag.x[0]) begin
                    if (w_s3_tag.last_col) begin
                        // odd line width: the trailing even pixel carries its own chroma
                        uv_valid     <= 1'b1;
                        u_out        <= w_s3_yuv.u;
                        v_out        <= w_s3_yuv.v;
                        r_hold_valid <= 1'b0;
                    end else begin
                        // an sof pixel lands here too, replacing any orphaned hold
                        r_hold_u     <= w_s3_yuv.u;
                        r_hold_v     <= w_s3_yuv.v;
                        r_hold_valid <= 1'b1;
                    end
                end else if (r_hold_valid) begin
                    uv_valid     <= 1'b1;
                    u_out        <= w_u_avg;
                    v_out        <= w_v_avg;
                    r_hold_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rgb_to_yuv422p.sv
// tb/tb_rgb_to_yuv422p.sv - directed and table-driven bench for rgb_to_yuv422p
module tb_rgb_to_yuv422p;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       data_valid = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] r_in = '0, g_in = '0, b_in = '0;

    logic       a_y_valid, a_uv_valid, a_frame_end;
    logic [7:0] a_y_out, a_u_out, a_v_out;
    logic [9:0] a_pixel_x, a_pixel_y;
    logic       b_y_valid, b_uv_valid, b_frame_end;
    logic [7:0] b_y_out, b_u_out, b_v_out;
    logic [9:0] b_pixel_x, b_pixel_y;

    always #5 clk = ~clk;

    rgb_to_yuv422p #(.IMG_WIDTH(320), .IMG_HEIGHT(466)) dut_a (
        .clk(clk), .rst(rst), .data_valid(data_valid), .sof(sof),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .y_valid(a_y_valid), .y_out(a_y_out), .uv_valid(a_uv_valid),
        .u_out(a_u_out), .v_out(a_v_out), .pixel_x(a_pixel_x),
        .pixel_y(a_pixel_y), .frame_end(a_frame_end)
    );

    rgb_to_yuv422p #(.IMG_WIDTH(5), .IMG_HEIGHT(2)) dut_b (
        .clk(clk), .rst(rst), .data_valid(data_valid), .sof(sof),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .y_valid(b_y_valid), .y_out(b_y_out), .uv_valid(b_uv_valid),
        .u_out(b_u_out), .v_out(b_v_out), .pixel_x(b_pixel_x),
        .pixel_y(b_pixel_y), .frame_end(b_frame_end)
    );

    typedef struct {
        logic [7:0] r, g, b;
        logic [7:0] ey, eu, ev;
    } vec_t;

    typedef struct packed {
        logic [7:0] y;
        logic [9:0] x;
        logic [9:0] yy;
        logic       fe;
    } yrec_t;

    typedef struct packed {
        logic [7:0] u;
        logic [7:0] v;
    } uvrec_t;

    typedef yrec_t  yq_t[$];
    typedef uvrec_t uvq_t[$];

    vec_t vt[8];
    yq_t  act_y0, act_y1, exp_y0, exp_y1;
    uvq_t act_uv0, act_uv1, exp_uv0, exp_uv1;

    int checks = 0;
    int errors = 0;
    int stray  = 0;

    int m_x[2], m_y[2], m_hold[2];
    bit m_hold_ok[2];
    int mw[2] = '{320, 5};
    int mh[2] = '{466, 2};

    always @(negedge clk) begin
        if (!rst) begin
            if (a_y_valid)  act_y0.push_back({a_y_out, a_pixel_x, a_pixel_y, a_frame_end});
            if (a_uv_valid) act_uv0.push_back({a_u_out, a_v_out});
            if (b_y_valid)  act_y1.push_back({b_y_out, b_pixel_x, b_pixel_y, b_frame_end});
            if (b_uv_valid) act_uv1.push_back({b_u_out, b_v_out});
            if ((a_frame_end || a_uv_valid) && !a_y_valid) stray++;
            if ((b_frame_end || b_uv_valid) && !b_y_valid) stray++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        act_y0.delete(); act_y1.delete(); exp_y0.delete(); exp_y1.delete();
        act_uv0.delete(); act_uv1.delete(); exp_uv0.delete(); exp_uv1.delete();
        for (int d = 0; d < 2; d++) begin
            m_x[d] = 0; m_y[d] = 0; m_hold[d] = 0; m_hold_ok[d] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; data_valid = 1'b0; sof = 1'b0;
        tick(); tick();
        rst = 1'b0;
        clear_all();
    endtask

    task automatic push_exp(input int d, input yrec_t e);
        if (d == 0) exp_y0.push_back(e); else exp_y1.push_back(e);
    endtask

    task automatic push_uv(input int d, input uvrec_t c);
        if (d == 0) exp_uv0.push_back(c); else exp_uv1.push_back(c);
    endtask

    // Reference: raster position, sof restart, 4:2:2 pairing with odd-width tail
    task automatic model_pixel(input int d, input int ci, input bit s);
        int x, y;
        yrec_t e;
        uvrec_t c;
        x = s ? 0 : m_x[d];
        y = s ? 0 : m_y[d];
        e.y  = vt[ci].ey;
        e.x  = 10'(x);
        e.yy = 10'(y);
        e.fe = (x == mw[d] - 1) && (y == mh[d] - 1);
        push_exp(d, e);
        if (x % 2 == 0) begin
            if (x == mw[d] - 1) begin
                c.u = vt[ci].eu; c.v = vt[ci].ev;
                push_uv(d, c);
                m_hold_ok[d] = 1'b0;
            end else begin
                m_hold[d] = ci; m_hold_ok[d] = 1'b1;
            end
        end else if (m_hold_ok[d]) begin
            c.u = 8'((int'(vt[m_hold[d]].eu) + int'(vt[ci].eu) + 1) / 2);
            c.v = 8'((int'(vt[m_hold[d]].ev) + int'(vt[ci].ev) + 1) / 2);
            push_uv(d, c);
            m_hold_ok[d] = 1'b0;
        end
        if (x == mw[d] - 1) begin
            m_x[d] = 0;
            m_y[d] = (y == mh[d] - 1) ? 0 : y + 1;
        end else begin
            m_x[d] = x + 1;
            m_y[d] = y;
        end
    endtask

    task automatic send(input int ci, input bit s, input int gap);
        data_valid = 1'b1; sof = s;
        r_in = vt[ci].r; g_in = vt[ci].g; b_in = vt[ci].b;
        model_pixel(0, ci, s);
        model_pixel(1, ci, s);
        tick();
        data_valid = 1'b0; sof = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic cmp_y(input string tag, input yq_t act, input yq_t exp);
        chk({tag, " y_count"}, 64'(act.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < act.size(); i++)
            chk($sformatf("%s y_rec[%0d]", tag, i), 64'(act[i]), 64'(exp[i]));
    endtask

    task automatic cmp_uv(input string tag, input uvq_t act, input uvq_t exp);
        chk({tag, " uv_count"}, 64'(act.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < act.size(); i++)
            chk($sformatf("%s uv_rec[%0d]", tag, i), 64'(act[i]), 64'(exp[i]));
    endtask

    task automatic finish_phase(input string tag);
        data_valid = 1'b0; sof = 1'b0;
        repeat (8) tick();
        cmp_y({tag, " A"}, act_y0, exp_y0);
        cmp_uv({tag, " A"}, act_uv0, exp_uv0);
        cmp_y({tag, " B"}, act_y1, exp_y1);
        cmp_uv({tag, " B"}, act_uv1, exp_uv1);
    endtask

    function automatic int count_fe(input yq_t q);
        int n = 0;
        foreach (q[i]) if (q[i].fe) n++;
        return n;
    endfunction

    initial begin
        vt[0] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd128, 8'd128};
        vt[1] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd128, 8'd128};
        vt[2] = '{8'd255, 8'd0,   8'd0,   8'd77,  8'd85,  8'd255};
        vt[3] = '{8'd0,   8'd0,   8'd255, 8'd29,  8'd255, 8'd107};
        vt[4] = '{8'd0,   8'd255, 8'd0,   8'd149, 8'd43,  8'd21};
        vt[5] = '{8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128};
        vt[6] = '{8'd100, 8'd50,  8'd200, 8'd82,  8'd195, 8'd141};
        vt[7] = '{8'd10,  8'd200, 8'd30,  8'd124, 8'd75,  8'd47};

        // reset state
        tick(); tick();
        @(negedge clk);
        chk("reset outputs A", 64'({a_y_valid, a_y_out, a_uv_valid, a_u_out, a_v_out, a_pixel_x, a_pixel_y, a_frame_end}), 64'd0);
        chk("reset outputs B", 64'({b_y_valid, b_y_out, b_uv_valid, b_u_out, b_v_out, b_pixel_x, b_pixel_y, b_frame_end}), 64'd0);
        do_reset();

        // latency: two white pixels, luma at N+4, chroma with the second at N+5
        data_valid = 1'b1; r_in = 8'd255; g_in = 8'd255; b_in = 8'd255;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 2) data_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("lat y_valid c%0d", c), 64'(a_y_valid), 64'(c == 4 || c == 5));
            chk($sformatf("lat uv_valid c%0d", c), 64'(a_uv_valid), 64'(c == 5));
            if (c == 4 || c == 5) begin
                chk($sformatf("lat y_out c%0d", c), 64'(a_y_out), 64'd255);
                chk($sformatf("lat pixel_x c%0d", c), 64'(a_pixel_x), 64'(c - 4));
            end
            if (c == 5) chk("lat uv c5", 64'({a_u_out, a_v_out}), 64'h8080);
        end
        tick();
        do_reset();

        // table: each colour sent as a pair so the averaged chroma equals the per-pixel value
        for (int i = 0; i < 8; i++) begin
            send(i, 1'b0, 0);
            send(i, 1'b0, 0);
            repeat (6) tick();
            chk($sformatf("vec%0d y_count", i), 64'(act_y0.size()), 64'd2);
            chk($sformatf("vec%0d uv_count", i), 64'(act_uv0.size()), 64'd1);
            if (act_y0.size() >= 2) begin
                chk($sformatf("vec%0d y0", i), 64'(act_y0[0].y), 64'(vt[i].ey));
                chk($sformatf("vec%0d y1", i), 64'(act_y0[1].y), 64'(vt[i].ey));
            end
            if (act_uv0.size() >= 1)
                chk($sformatf("vec%0d uv", i), 64'(act_uv0[0]), 64'({vt[i].eu, vt[i].ev}));
            act_y0.delete(); act_uv0.delete(); act_y1.delete(); act_uv1.delete();
        end
        do_reset();

        // red then blue: clamped per-pixel chroma averaged across the pair
        send(2, 1'b0, 0);
        send(3, 1'b0, 0);
        repeat (6) tick();
        if (act_uv0.size() >= 1) chk("red/blue uv", 64'(act_uv0[0]), 64'({8'd170, 8'd181}));
        else chk("red/blue uv present", 64'(act_uv0.size()), 64'd1);
        finish_phase("red_blue");
        do_reset();

        // black stream with gaps: wraps x at 319 on A, whole frames on B
        for (int k = 0; k < 330; k++) send(1, 1'b0, int'($urandom_range(0, 2)));
        finish_phase("black_gaps");
        chk("black A last pixel_y", 64'(a_pixel_y), 64'd1);
        do_reset();

        // odd width on B: tail pixel emits its own chroma, frame_end per frame
        for (int k = 0; k < 24; k++) send(int'($urandom_range(0, 7)), 1'b0, int'($urandom_range(0, 1)));
        finish_phase("odd_width");
        chk("odd_width B uv_count hand", 64'(act_uv1.size()), 64'd14);
        chk("odd_width B frame_end count", 64'(count_fe(act_y1)), 64'd2);
        do_reset();

        // sof after an even pixel at x=2 drops the hold; truncated frame has no frame_end
        send(2, 1'b0, 0);
        send(3, 1'b0, 1);
        send(6, 1'b0, 0);
        send(4, 1'b1, 0);
        for (int k = 0; k < 9; k++) send(k % 8, 1'b0, k % 2);
        finish_phase("sof");
        chk("sof B uv_count hand", 64'(act_uv1.size()), 64'd7);
        chk("sof B frame_end count", 64'(count_fe(act_y1)), 64'd1);
        if (act_y1.size() > 3) chk("sof B restart xy", 64'({act_y1[3].x, act_y1[3].yy}), 64'd0);
        do_reset();

        // reset with three pixels in flight
        data_valid = 1'b1; r_in = 8'd255; g_in = 8'd255; b_in = 8'd255;
        tick();
        r_in = 8'd10;
        tick();
        g_in = 8'd99;
        tick();
        rst = 1'b1; data_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("midrst outputs A", 64'({a_y_valid, a_y_out, a_uv_valid, a_u_out, a_v_out, a_pixel_x, a_pixel_y, a_frame_end}), 64'd0);
        chk("midrst outputs B", 64'({b_y_valid, b_y_out, b_uv_valid, b_u_out, b_v_out, b_pixel_x, b_pixel_y, b_frame_end}), 64'd0);
        tick();
        rst = 1'b0;
        clear_all();
        repeat (6) tick();
        chk("midrst stale y A", 64'(act_y0.size()), 64'd0);
        chk("midrst stale uv A", 64'(act_uv0.size()), 64'd0);
        send(5, 1'b0, 0);
        send(6, 1'b0, 0);
        finish_phase("after_rst");

        chk("stray uv/frame_end", 64'(stray), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
